// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct values and the
// list of operations that trap on signed overflow.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_AND     = 4'd2,
    ALU_OR      = 4'd3,
    ALU_SLL     = 4'd4,
    ALU_SRL     = 4'd5,
    ALU_SRA     = 4'd6,
    ALU_GREATER = 4'd7,
    ALU_LESS    = 4'd8,
    ALU_NOR     = 4'd9
  } alu_op_t;

  // Where the second operand comes from.
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2
  } imm_sel_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Only the signed add/sub forms raise an overflow trap.
  function automatic logic is_trapping(input logic [5:0] opcode, input logic [5:0] funct);
    return ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
           (opcode == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode: maps opcode/funct onto an ALU operation,
// operand source, shift flag, overflow-trap flag and an illegal indication.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_control,
  output imm_sel_t   imm_sel,
  output logic       shift,
  output logic       trap,
  output logic       illegal
);

  // Table decode; anything not listed falls through to illegal.
  always_comb begin
    alu_control = ALU_ADD;
    imm_sel     = IMM_NONE;
    shift       = 1'b0;
    illegal     = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: alu_control = ALU_SUB;
        FN_AND:          alu_control = ALU_AND;
        FN_OR:           alu_control = ALU_OR;
        FN_NOR:          alu_control = ALU_NOR;
        FN_SLT:          alu_control = ALU_LESS;
        FN_SLL: begin alu_control = ALU_SLL; shift = 1'b1; end
        FN_SRL: begin alu_control = ALU_SRL; shift = 1'b1; end
        FN_SRA: begin alu_control = ALU_SRA; shift = 1'b1; end
        default:         illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin alu_control = ALU_ADD;  imm_sel = IMM_SIGN; end
        OP_SLTI:                         begin alu_control = ALU_LESS; imm_sel = IMM_SIGN; end
        OP_ANDI:                         begin alu_control = ALU_AND;  imm_sel = IMM_ZERO; end
        OP_ORI:                          begin alu_control = ALU_OR;   imm_sel = IMM_ZERO; end
        OP_BEQ, OP_BNE:                  alu_control = ALU_SUB;
        default:                         illegal = 1'b1;
      endcase
    end
  end

  assign trap = is_trapping(opcode, funct);

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue stage: decodes an accepted instruction into a one-entry issue
// register and tracks trapping ops until their overflow result comes back.
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [3:0]  alu_control,
  output logic [4:0]  shift_amount,
  input  logic        alu_overflow,
  output logic        illegal_instr,
  output logic        ovf_trap
);

  alu_op_t     dec_op;
  imm_sel_t    dec_imm;
  logic        dec_shift;
  logic        dec_trap;
  logic        dec_illegal;
  logic [31:0] next_data1;
  logic [31:0] next_data2;
  logic [4:0]  next_shamt;
  logic        ex_trap;
  logic [1:0]  pend;
  logic        trap_hit;
  logic        kill;

  // Register specifiers are resolved upstream; their values arrive on rs_data/rt_data.
  logic unused_reg_fields;
  assign unused_reg_fields = ^instr[25:16];

  alu_ctrl_decode u_decode (
    .opcode      (instr[31:26]),
    .funct       (instr[5:0]),
    .alu_control (dec_op),
    .imm_sel     (dec_imm),
    .shift       (dec_shift),
    .trap        (dec_trap),
    .illegal     (dec_illegal)
  );

  // Operand selection: shifts take rt as the shifted value, immediates replace rt.
  always_comb begin
    next_data1 = dec_shift ? rt_data : rs_data;
    next_shamt = dec_shift ? instr[10:6] : 5'd0;
    case (dec_imm)
      IMM_SIGN: next_data2 = {{16{instr[15]}}, instr[15:0]};
      IMM_ZERO: next_data2 = {16'h0000, instr[15:0]};
      default:  next_data2 = rt_data;
    endcase
  end

  // An overflow trap behaves exactly like an external flush on the same edge.
  assign trap_hit = pend[1] & alu_overflow;
  assign kill     = flush | trap_hit;
  assign in_ready = ~stall & ~reset;

  // Issue register: kill beats stall, stall holds, otherwise load or go idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      data1         <= 32'd0;
      data2         <= 32'd0;
      alu_control   <= ALU_ADD;
      shift_amount  <= 5'd0;
      ex_trap       <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      illegal_instr <= 1'b0;
      if (kill) begin
        ex_valid <= 1'b0;
      end else if (!stall) begin
        if (in_valid && !dec_illegal) begin
          ex_valid     <= 1'b1;
          data1        <= next_data1;
          data2        <= next_data2;
          alu_control  <= dec_op;
          shift_amount <= next_shamt;
          ex_trap      <= dec_trap;
        end else begin
          ex_valid      <= 1'b0;
          illegal_instr <= in_valid;
        end
      end
    end
  end

  // Trap tracking: a trapping op walks two stages to reach its ALU-result cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= 2'b00;
      ovf_trap <= 1'b0;
    end else begin
      ovf_trap <= trap_hit;
      if (kill) begin
        pend <= 2'b00;
      end else if (!stall) begin
        pend <= {pend[0], ex_valid & ex_trap};
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, alu_overflow;
  logic [31:0] instr, rs_data, rt_data;
  logic        in_ready, ex_valid, illegal_instr, ovf_trap;
  logic [31:0] data1, data2;
  logic [3:0]  alu_control;
  logic [4:0]  shift_amount;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: issued op plus ages of trapping ops past issue.
  logic        m_valid, m_ill, m_ovf, m_trapop;
  logic [31:0] m_d1, m_d2;
  logic [3:0]  m_op;
  logic [4:0]  m_sh;
  int          ages[$];

  typedef struct packed {
    logic        legal;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  sh;
    logic        trap;
  } exp_t;

  alu_issue_unit dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .data1         (data1),
    .data2         (data2),
    .alu_control   (alu_control),
    .shift_amount  (shift_amount),
    .alu_overflow  (alu_overflow),
    .illegal_instr (illegal_instr),
    .ovf_trap      (ovf_trap)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    logic [31:0] w;
    w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    return w;
  endfunction

  // Reference decode straight from the instruction table.
  function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    int          opc, fn;
    logic [31:0] zext, sext;
    opc  = int'(w[31:26]);
    fn   = int'(w[5:0]);
    zext = 32'(w[15:0]);
    sext = w[15] ? (zext - 32'h0001_0000) : zext;
    e.legal = 1'b1; e.op = 4'd0; e.d1 = rs; e.d2 = rt; e.sh = 5'd0; e.trap = 1'b0;
    if (opc == 0) begin
      case (fn)
        'h20: begin e.op = 4'd0; e.trap = 1'b1; end
        'h21: e.op = 4'd0;
        'h22: begin e.op = 4'd1; e.trap = 1'b1; end
        'h23: e.op = 4'd1;
        'h24: e.op = 4'd2;
        'h25: e.op = 4'd3;
        'h27: e.op = 4'd9;
        'h2A: e.op = 4'd8;
        'h00, 'h02, 'h03: begin
          e.op = (fn == 'h00) ? 4'd4 : (fn == 'h02) ? 4'd5 : 4'd6;
          e.d1 = rt;
          e.sh = w[10:6];
        end
        default: e.legal = 1'b0;
      endcase
    end else begin
      case (opc)
        'h08:               begin e.op = 4'd0; e.d2 = sext; e.trap = 1'b1; end
        'h09, 'h23, 'h2B:   begin e.op = 4'd0; e.d2 = sext; end
        'h0A:               begin e.op = 4'd8; e.d2 = sext; end
        'h0C:               begin e.op = 4'd2; e.d2 = zext; end
        'h0D:               begin e.op = 4'd3; e.d2 = zext; end
        'h04, 'h05:         e.op = 4'd1;
        default:            e.legal = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit   due;
    exp_t e;
    due = 0;
    foreach (ages[i]) if (ages[i] == 2) due = 1;
    if (reset) begin
      m_valid = 0; m_d1 = 0; m_d2 = 0; m_op = 0; m_sh = 0;
      m_ill = 0; m_ovf = 0; m_trapop = 0;
      ages.delete();
    end else begin
      m_ovf = due && alu_overflow;
      m_ill = 0;
      if (flush || m_ovf) begin
        m_valid = 0;
        ages.delete();
      end else if (!stall) begin
        foreach (ages[i]) ages[i] = ages[i] + 1;
        while (ages.size() > 0 && ages[0] > 2) void'(ages.pop_front());
        if (m_valid && m_trapop) ages.push_back(1);
        e = refDecode(instr, rs_data, rt_data);
        if (in_valid && e.legal) begin
          m_valid = 1; m_d1 = e.d1; m_d2 = e.d2; m_op = e.op; m_sh = e.sh; m_trapop = e.trap;
        end else begin
          m_valid = 0;
          m_ill   = in_valid;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    checkOutput({tag, ".data1"}, data1, m_d1);
    checkOutput({tag, ".data2"}, data2, m_d2);
    checkOutput({tag, ".alu_control"}, 32'(alu_control), 32'(m_op));
    checkOutput({tag, ".shift_amount"}, 32'(shift_amount), 32'(m_sh));
    checkOutput({tag, ".illegal_instr"}, 32'(illegal_instr), 32'(m_ill));
    checkOutput({tag, ".ovf_trap"}, 32'(ovf_trap), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, check in_ready, clock the DUT and model, compare.
  task automatic applyStimulus(input string tag, input logic rst, input logic v, input logic [31:0] w,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic st, input logic fl, input logic ov);
    reset = rst; in_valid = v; instr = w; rs_data = rs; rt_data = rt;
    stall = st; flush = fl; alu_overflow = ov;
    #2;
    checkOutput({tag, ".in_ready"}, 32'(in_ready), (st || rst) ? 32'd0 : 32'd1);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    int opcs[15] = '{'h00, 'h00, 'h00, 'h00, 'h08, 'h09, 'h23, 'h2B, 'h0A, 'h0C, 'h0D, 'h04, 'h05, 'h3F, 'h02};
    int fns[13]  = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h27, 'h2A, 'h00, 'h02, 'h03, 'h08, 'h1F};
    int pulses;
    logic [31:0] w;

    $display("[TB] reset phase");
    applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 1, 1, rtype(1, 2, 3, 0, 'h20), 9, 9, 0, 0, 0);
    checkOutput("reset.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset.alu_control", 32'(alu_control), 32'd0);
    checkOutput("reset.data1", data1, 32'd0);

    $display("[TB] directed decode");
    applyStimulus("add", 0, 1, rtype(1, 2, 3, 0, 'h20), 5, 7, 0, 0, 0);
    checkOutput("add.ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("add.alu_control", 32'(alu_control), 32'd0);
    checkOutput("add.data1", data1, 32'd5);
    checkOutput("add.data2", data2, 32'd7);

    applyStimulus("sra", 0, 1, rtype(0, 2, 3, 4, 'h03), 32'h1111_1111, 32'h8000_0000, 0, 0, 0);
    checkOutput("sra.alu_control", 32'(alu_control), 32'd6);
    checkOutput("sra.data1", data1, 32'h8000_0000);
    checkOutput("sra.shift_amount", 32'(shift_amount), 32'd4);

    applyStimulus("andi", 0, 1, itype('h0C, 1, 2, 'hFFFF), 32'h1234_5678, 0, 0, 0, 0);
    checkOutput("andi.data2", data2, 32'h0000_FFFF);
    applyStimulus("addi", 0, 1, itype('h08, 1, 2, 'hFFFF), 32'h1234_5678, 0, 0, 0, 0);
    checkOutput("addi.data2", data2, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) applyStimulus("drain", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] overflow trap");
    applyStimulus("ovf.issue", 0, 1, rtype(1, 2, 3, 0, 'h20), 32'h7FFF_FFFF, 1, 0, 0, 0);
    applyStimulus("ovf.wait0", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("ovf.wait1", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ovf.pre", 32'(ovf_trap), 32'd0);
    applyStimulus("ovf.hit", 0, 1, rtype(1, 2, 3, 0, 'h21), 3, 4, 0, 0, 1);
    checkOutput("ovf.trap", 32'(ovf_trap), 32'd1);
    checkOutput("ovf.ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus("ovf.after", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ovf.one_pulse", 32'(ovf_trap), 32'd0);

    pulses = 0;
    applyStimulus("addu.issue", 0, 1, rtype(1, 2, 3, 0, 'h21), 32'h7FFF_FFFF, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("addu.wait", 0, 0, 0, 0, 0, 0, 0, 1);
      if (ovf_trap) pulses++;
    end
    checkOutput("addu.no_trap", 32'(pulses), 32'd0);

    $display("[TB] illegal, stall, flush, reset");
    applyStimulus("or", 0, 1, rtype(1, 2, 3, 0, 'h25), 32'hAAAA_0000, 32'h0000_5555, 0, 0, 0);
    applyStimulus("illegal", 0, 1, 32'hFC00_0000, 1, 2, 0, 0, 0);
    checkOutput("illegal.pulse", 32'(illegal_instr), 32'd1);
    checkOutput("illegal.ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("illegal.data1_kept", data1, 32'hAAAA_0000);
    applyStimulus("illegal.after", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("illegal.one_pulse", 32'(illegal_instr), 32'd0);

    applyStimulus("sub", 0, 1, rtype(1, 2, 3, 0, 'h22), 32'd100, 32'd1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 0, 1, itype('h0D, 1, 2, 'h1234), 32'd9, 32'd9, 1, 0, 0);
      checkOutput("stall.ex_valid", 32'(ex_valid), 32'd1);
      checkOutput("stall.data1", data1, 32'd100);
      checkOutput("stall.alu_control", 32'(alu_control), 32'd1);
    end
    applyStimulus("flush", 0, 1, rtype(1, 2, 3, 0, 'h20), 32'd4, 32'd4, 0, 1, 0);
    checkOutput("flush.ex_valid", 32'(ex_valid), 32'd0);

    applyStimulus("pre_reset", 0, 1, rtype(1, 2, 3, 0, 'h24), 32'hF0F0, 32'hFF00, 0, 0, 0);
    applyStimulus("mid_reset", 1, 1, rtype(1, 2, 3, 0, 'h24), 32'hF0F0, 32'hFF00, 0, 0, 0);
    checkOutput("mid_reset.ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus("post_reset", 0, 1, rtype(1, 2, 3, 0, 'h27), 32'd1, 32'd2, 0, 0, 0);
    checkOutput("post_reset.ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("post_reset.alu_control", 32'(alu_control), 32'd9);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[31:26] = 6'(opcs[$urandom_range(14, 0)]);
      w[5:0]   = 6'(fns[$urandom_range(12, 0)]);
      applyStimulus("rand",
                    ($urandom_range(99, 0) == 0),
                    ($urandom_range(3, 0) != 0),
                    w, $urandom, $urandom,
                    ($urandom_range(4, 0) == 0),
                    ($urandom_range(11, 0) == 0),
                    ($urandom_range(2, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  instruction word and operands valid this cycle.
REQ-004 in_ready  output  1  unit accepts an instruction this cycle; equals ~stall & ~reset.
REQ-005 instr  input  32  MIPS instruction word.
REQ-006 rs_data, rt_data  input  32 each  register operands for rs and rt.
REQ-007 stall  input  1  hold the issue register unchanged.
REQ-008 flush  input  1  kill the issue register and all in-flight trap tracking.
REQ-009 ex_valid  output  1  issue-register contents are a live ALU operation.
REQ-010 data1, data2  output  32 each  ALU operands.
REQ-011 alu_control  output  4  ALU operation code.
REQ-012 shift_amount  output  5  shift count for the ALU.
REQ-013 alu_overflow  input  1  overflow flag returned by the ALU.
REQ-014 illegal_instr  output  1  one-cycle pulse for an undecodable accepted instruction.
REQ-015 ovf_trap  output  1  one-cycle pulse for signed overflow on a trapping op.

Function
REQ-016 ALU code encoding: ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, SRA=6, GREATER=7, LESS=8, NOR=9.
REQ-017 R-type decode (opcode 0), by funct:
- 0x20 add, 0x21 addu -> ADD
- 0x22 sub, 0x23 subu -> SUB
- 0x24 -> AND; 0x25 -> OR; 0x27 -> NOR
- 0x2A slt -> LESS
- 0x00 -> SLL; 0x02 -> SRL; 0x03 -> SRA
REQ-018 R-type operands: data2=rt_data; data1=rs_data, except shifts where data1=rt_data and shift_amount=instr[10:6]; shift_amount=0 for non-shifts.
REQ-019 I-type decode, data1=rs_data:
- addi 0x08, addiu 0x09, lw 0x23, sw 0x2B -> ADD with sign-extended imm16
- slti 0x0A -> LESS with sign-extended imm16
- andi 0x0C -> AND, ori 0x0D -> OR, both with zero-extended imm16
- beq 0x04, bne 0x05 -> SUB with data2=rt_data
REQ-020 Trapping ops are exactly add, sub and addi; all others never raise ovf_trap.
REQ-021 Issue register update (priority order):
- flush -> ex_valid=0
- else stall -> hold all outputs
- else in_valid -> load decoded fields, ex_valid=1
- else ex_valid=0
Issue latency is one cycle.
REQ-022 Any other opcode/funct -> illegal_instr=1 the cycle after acceptance, ex_valid=0, operand fields unchanged.
REQ-023 Trap tracking: a 2-bit shift register pend[1:0].
- pend[0] loads (ex_valid & trapping) at each non-stalled edge.
- pend[1] follows pend[0].
- ovf_trap = pend[1] & alu_overflow, registered so it pulses one cycle, i.e. alu_overflow is sampled in the ALU-result cycle of the tracked op.
REQ-024 ovf_trap forces flush behaviour internally on the same edge: ex_valid=0 and pend cleared.
REQ-025 Simultaneous flush and in_valid: flush wins and the instruction is dropped; in_ready still reflects stall only.
REQ-026 Stall while ex_valid=1: outputs held; pend does not advance.
REQ-027 Back-to-back accepted instructions issue every cycle with no bubble.

Reset
REQ-028 While reset is high: ex_valid=0, data1=0, data2=0, alu_control=ADD, shift_amount=0, pend=0, illegal_instr=0, ovf_trap=0, in_ready=0.
REQ-029 Reset mid-operation discards the issue register and pending traps; the first accept is possible the cycle after reset deasserts.

Structure
REQ-030 ALU code constants, opcode/funct constants and the trapping-op list reside in the shared package alu_pkg, which the ALU also uses.
REQ-031 Combinational decode resides in sub-module alu_ctrl_decode (instr -> alu_control, imm select, shift flag, trap flag, illegal); alu_issue_unit holds registers and tracking.

Verification
REQ-032 add $3,$1,$2 with rs=5, rt=7 -> next cycle ex_valid=1, alu_control=0, data1=5, data2=7.
REQ-033 sra with rt=0x80000000, shamt=4 -> alu_control=6, data1=0x80000000, shift_amount=4.
REQ-034 andi imm=0xFFFF with rs=0x12345678 -> data2=0x0000FFFF; addi imm=0xFFFF -> data2=0xFFFFFFFF.
REQ-035 add with rs=0x7FFFFFFF, rt=1, ALU returns alu_overflow=1 in the result cycle -> ovf_trap pulses once and ex_valid=0 next; the same operands with addu -> no ovf_trap.
REQ-036 opcode 0x3F -> illegal_instr pulses one cycle and ex_valid=0; stall held 3 cycles -> outputs constant; flush together with in_valid -> ex_valid=0.
